led_scan_driver: RTL and testbench

Time-multiplexed driver for a multi-digit 7-segment display, directly downstream of the BCD-to-7-segment decoders. It takes one 8-bit segment pattern per digit and scans the digits onto a shared segment bus with a one-hot digit select. A per-slot blanking interval suppresses ghosting. All digits are snapshotted once per frame so the display never tears.

---
 rtl/led_pkg.sv | 22 ++
 rtl/scan_prescaler.sv | 57 +++++
 rtl/led_scan_driver.sv | 134 +++++++++++++
 tb/tb_led_scan_driver.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the 7-segment display path: segment patterns,
// scan mode encoding and the digit-select helper.
package led_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Active-high g..a patterns for decimal digits 0..9, dp clear
    localparam logic [7:0] SEG_DIGIT [10] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mode_e;

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        onehot = 8'h01 << idx;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot timer: counts clk cycles within a slot and reports the slot end
// and whether the digit will be lit in the next cycle.
module scan_prescaler #(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 1000,
    localparam int PW      = $clog2(PRESCALE)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic slot_end,
    output logic visible_next
);

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_s;

    assign slot_end = (presc_r == PRESC_LAST);

    // Next count: cleared outside an active scan, wraps at the slot end
    always_comb begin
        presc_s = presc_r;
        if (clr) begin
            presc_s = '0;
        end else if (inc) begin
            if (slot_end) begin
                presc_s = '0;
            end else begin
                presc_s = presc_r + PW'(1);
            end
        end else begin
            presc_s = presc_r;
        end
    end

    // Visibility is judged on the next count so the driver can register it
    generate
        if (BLANK == 0) begin : g_no_blank
            assign visible_next = 1'b1;
        end else begin : g_blank
            assign visible_next = (presc_s >= PW'(BLANK));
        end
    endgenerate

    // Slot counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_s;
        end
    end

endmodule

// File: rtl/led_scan_driver.sv
// Time-multiplexed 7-segment scanner: snapshots all digit patterns once per
// frame and drives them one at a time with a blanking gap at each slot start.
module led_scan_driver
    import led_pkg::*;
#(
    parameter int DIGITS           = 4,
    parameter int PRESCALE         = 50000,
    parameter int BLANK            = 1000,
    parameter int ANODE_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [8*DIGITS-1:0]   seg_in,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_tick
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_IDLE = (ANODE_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    mode_e               mode_r;
    mode_e               mode_s;
    logic [IW-1:0]       idx_r;
    logic [IW-1:0]       idx_s;
    logic [8*DIGITS-1:0] snap_r;
    logic [8*DIGITS-1:0] snap_s;
    logic                tick_s;
    logic                run_s;
    logic                slot_end_s;
    logic                visible_s;
    logic [7:0]          onehot_s;
    logic [7:0]          pick_s;
    logic [7:0]          seg_s;
    logic [DIGITS-1:0]   sel_s;
    logic                unused_onehot_s;

    assign run_s = (mode_r == RUN) && en;

    scan_prescaler #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) u_prescaler (
        .clk          (clk),
        .rst          (rst),
        .clr          (!run_s),
        .inc          (run_s),
        .slot_end     (slot_end_s),
        .visible_next (visible_s)
    );

    // Mode, digit index and frame snapshot for the next cycle
    always_comb begin
        mode_s = mode_r;
        idx_s  = idx_r;
        snap_s = snap_r;
        tick_s = 1'b0;
        if (!en) begin
            mode_s = IDLE;
            idx_s  = '0;
        end else begin
            case (mode_r)
                IDLE: begin
                    mode_s = RUN;
                    idx_s  = '0;
                    snap_s = seg_in;
                    tick_s = 1'b1;
                end
                RUN: begin
                    if (slot_end_s) begin
                        if (idx_r == IDX_LAST) begin
                            idx_s  = '0;
                            snap_s = seg_in;
                            tick_s = 1'b1;
                        end else begin
                            idx_s = idx_r + IW'(1);
                        end
                    end else begin
                        idx_s = idx_r;
                    end
                end
                default: begin
                    mode_s = IDLE;
                    idx_s  = '0;
                end
            endcase
        end
    end

    // Select the snapshot byte for the next digit index
    always_comb begin
        pick_s = SEG_BLANK;
        for (int i = 0; i < DIGITS; i++) begin
            pick_s = pick_s | (snap_s[8*i +: 8] & {8{idx_s == IW'(i)}});
        end
    end

    assign onehot_s = onehot(3'(idx_s));
    // Bits above DIGITS-1 can never be set by a legal index
    assign unused_onehot_s = ^onehot_s;

    // Visible digit or blank bus, polarity applied to the select
    always_comb begin
        if ((mode_s == RUN) && visible_s) begin
            seg_s = pick_s;
            sel_s = onehot_s[DIGITS-1:0] ^ SEL_IDLE;
        end else begin
            seg_s = SEG_BLANK;
            sel_s = SEL_IDLE;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r     <= IDLE;
            idx_r      <= '0;
            snap_r     <= '0;
            seg_out    <= SEG_BLANK;
            dig_sel    <= SEL_IDLE;
            frame_tick <= 1'b0;
        end else begin
            mode_r     <= mode_s;
            idx_r      <= idx_s;
            snap_r     <= snap_s;
            seg_out    <= seg_s;
            dig_sel    <= sel_s;
            frame_tick <= tick_s;
        end
    end

endmodule

// File: tb/tb_led_scan_driver.sv
// Scoreboard bench for led_scan_driver across three parameter sets:
// blanked active-high, unblanked active-low, and a single-digit display.
module tb_led_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // DUT A: 4 digits, PRESCALE 4, BLANK 1, active-high
    logic        rst_a = 1'b1, en_a = 1'b0;
    logic [31:0] seg_in_a = 32'h0;
    logic [7:0]  seg_out_a;
    logic [3:0]  dig_a;
    logic        tick_a;
    // DUT B: 4 digits, PRESCALE 4, BLANK 0, active-low
    logic        rst_b = 1'b1, en_b = 1'b0;
    logic [31:0] seg_in_b = 32'h0;
    logic [7:0]  seg_out_b;
    logic [3:0]  dig_b;
    logic        tick_b;
    // DUT C: 1 digit, PRESCALE 2, BLANK 1
    logic        rst_c = 1'b1, en_c = 1'b0;
    logic [7:0]  seg_in_c = 8'h0;
    logic [7:0]  seg_out_c;
    logic [0:0]  dig_c;
    logic        tick_c;

    led_scan_driver #(.DIGITS(4), .PRESCALE(4), .BLANK(1), .ANODE_ACTIVE_LOW(0)) u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .seg_in(seg_in_a),
        .seg_out(seg_out_a), .dig_sel(dig_a), .frame_tick(tick_a));
    led_scan_driver #(.DIGITS(4), .PRESCALE(4), .BLANK(0), .ANODE_ACTIVE_LOW(1)) u_b (
        .clk(clk), .rst(rst_b), .en(en_b), .seg_in(seg_in_b),
        .seg_out(seg_out_b), .dig_sel(dig_b), .frame_tick(tick_b));
    led_scan_driver #(.DIGITS(1), .PRESCALE(2), .BLANK(1), .ANODE_ACTIVE_LOW(0)) u_c (
        .clk(clk), .rst(rst_c), .en(en_c), .seg_in(seg_in_c),
        .seg_out(seg_out_c), .dig_sel(dig_c), .frame_tick(tick_c));

    typedef struct packed {
        logic [1:0]  dut;
        logic [31:0] due;
        logic [7:0]  seg;
        logic [3:0]  dig;
        logic        tick;
        logic [7:0]  phase;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;
    bit   drained  = 1'b0;

    localparam logic [31:0] S1  = 32'h4F5B063F;
    localparam logic [31:0] S7F = 32'h7F7F7F7F;
    localparam logic [31:0] S2  = 32'h077D6D66;
    localparam logic [31:0] S3  = 32'h6F7F0706;

    // Drive one cycle of inputs and queue the outputs expected after the edge
    task automatic step(input int d, input logic r, input logic e, input logic [31:0] s,
                        input logic [7:0] xs, input logic [3:0] xd, input logic xt, input int ph);
        case (d)
            0:       begin rst_a = r; en_a = e; seg_in_a = s; end
            1:       begin rst_b = r; en_b = e; seg_in_b = s; end
            default: begin rst_c = r; en_c = e; seg_in_c = s[7:0]; end
        endcase
        sb.push_back('{dut: 2'(d), due: cyc + 32'd1, seg: xs, dig: xd, tick: xt, phase: 8'(ph)});
        @(posedge clk);
        #1;
    endtask

    // n cycles of an enabled scan starting at digit 0, slot position 0
    task automatic frame(input int d, input int nd, input int p, input int b, input bit al,
                         input int n, input logic [31:0] s_a, input int k_chg,
                         input logic [31:0] s_b, input logic [31:0] snap, input int ph);
        logic [3:0] mask, idle, oh, xd;
        logic [7:0] xs;
        mask = 4'((1 << nd) - 1);
        idle = al ? mask : 4'h0;
        for (int k = 0; k < n; k++) begin
            int idx;
            int pr;
            idx = k / p;
            pr  = k % p;
            if (pr < b) begin
                xs = 8'h00;
                xd = idle;
            end else begin
                xs = snap[8*idx +: 8];
                oh = 4'(1 << idx);
                xd = al ? (~oh & mask) : oh;
            end
            step(d, 1'b0, 1'b1, (k < k_chg) ? s_a : s_b, xs, xd, (k == 0), ph);
        end
    endtask

    function automatic bit bad_bus(input logic [7:0] s, input logic [3:0] act);
        return ($countones(act) > 1) || ((act == 4'h0) && (s != 8'h00));
    endfunction

    // Monitor: compare due scoreboard entries and bus invariants every cycle
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [7:0] gs;
        logic [3:0] gd;
        logic       gt;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.dut)
                2'd0:    begin gs = seg_out_a; gd = dig_a; gt = tick_a; end
                2'd1:    begin gs = seg_out_b; gd = dig_b; gt = tick_b; end
                default: begin gs = seg_out_c; gd = {3'b000, dig_c}; gt = tick_c; end
            endcase
            n_checks++;
            if (e.due != cyc || gs !== e.seg || gd !== e.dig || gt !== e.tick) begin
                n_fail++;
                $display("FAIL out_p%0d dut%0d cyc=%0d due=%0d: got seg=%h dig=%b tick=%b, expected seg=%h dig=%b tick=%b",
                         e.phase, e.dut, cyc, e.due, gs, gd, gt, e.seg, e.dig, e.tick);
            end
        end
        if (cyc > 2) begin
            n_checks += 3;
            if (bad_bus(seg_out_a, dig_a)) begin
                n_fail++;
                $display("FAIL inv_a cyc=%0d: seg=%h dig=%b", cyc, seg_out_a, dig_a);
            end
            if (bad_bus(seg_out_b, ~dig_b)) begin
                n_fail++;
                $display("FAIL inv_b cyc=%0d: seg=%h dig=%b", cyc, seg_out_b, dig_b);
            end
            if (bad_bus(seg_out_c, {3'b000, dig_c})) begin
                n_fail++;
                $display("FAIL inv_c cyc=%0d: seg=%h dig=%b", cyc, seg_out_c, dig_c);
            end
        end
        if (done && !drained) begin
            drained = 1'b1;
            n_checks++;
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL drain: %0d entries left, expected 0", sb.size());
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // Reset holds outputs idle even with en high
        repeat (3) step(0, 1'b1, 1'b1, S1, 8'h00, 4'h0, 1'b0, 1);
        // Basic scan, two frames to see frame_tick recur after 16 cycles
        frame(0, 4, 4, 1, 1'b0, 16, S1, 99, S1, S1, 2);
        // seg_in changes during slot 1 are held off until the next frame
        frame(0, 4, 4, 1, 1'b0, 16, S1, 5, S7F, S1, 3);
        frame(0, 4, 4, 1, 1'b0, 16, S7F, 99, S7F, S7F, 3);
        // Drop en at idx 2, presc 2 then restart with a fresh snapshot
        frame(0, 4, 4, 1, 1'b0, 11, S2, 99, S2, S2, 4);
        step(0, 1'b0, 1'b0, S2, 8'h00, 4'h0, 1'b0, 4);
        step(0, 1'b0, 1'b0, S2, 8'h00, 4'h0, 1'b0, 4);
        frame(0, 4, 4, 1, 1'b0, 16, S1, 99, S1, S1, 4);
        // Last cycle above was idx 3, presc 3: reset there
        step(0, 1'b1, 1'b1, S3, 8'h00, 4'h0, 1'b0, 6);
        frame(0, 4, 4, 1, 1'b0, 16, S3, 99, S3, S3, 6);
        rst_a = 1'b1;

        // Active-low selects without blanking
        step(1, 1'b1, 1'b0, S1, 8'h00, 4'hF, 1'b0, 5);
        step(1, 1'b0, 1'b0, S1, 8'h00, 4'hF, 1'b0, 5);
        frame(1, 4, 4, 0, 1'b1, 16, S1, 99, S1, S1, 5);
        frame(1, 4, 4, 0, 1'b1, 16, S2, 99, S2, S2, 5);
        rst_b = 1'b1;

        // Single digit: snapshot and frame_tick every 2 cycles
        step(2, 1'b1, 1'b0, 32'h06, 8'h00, 4'h0, 1'b0, 7);
        step(2, 1'b0, 1'b0, 32'h06, 8'h00, 4'h0, 1'b0, 7);
        frame(2, 1, 2, 1, 1'b0, 2, 32'h06, 99, 32'h06, 32'h06, 7);
        frame(2, 1, 2, 1, 1'b0, 2, 32'h5B, 99, 32'h5B, 32'h5B, 7);
        frame(2, 1, 2, 1, 1'b0, 2, 32'h4F, 1, 32'h3F, 32'h4F, 7);
        frame(2, 1, 2, 1, 1'b0, 2, 32'h3F, 99, 32'h3F, 32'h3F, 7);
        rst_c = 1'b1;

        repeat (2) @(posedge clk);
        done = 1'b1;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
